dmem_arbiter: RTL and testbench

- Shares the single-port 16x8 data memory between two requesters: the CPU datapath (port c_) and a host/debug port (port h_).
- Grants at most one access per cycle and drives the memory enable, write-enable, address and data-in.
- Routes the one-cycle-latency read data back to the requester that issued the read.
- The CPU has priority by default. A starvation counter guarantees host service. A bounded host lock supports host burst access.

---
 rtl/mcu_pkg.sv | 15 +
 rtl/arb_prio_sel.sv | 22 ++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared MCU widths and data-memory arbiter state encoding
package mcu_pkg;

  localparam int MCU_ADDR_W = 4;
  localparam int MCU_DATA_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_CPU_OWN   = 3'd1,
    ARB_HOST_OWN  = 3'd2,
    ARB_HOST_LOCK = 3'd3,
    ARB_FORCE_REL = 3'd4
  } arb_state_t;

endpackage

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - combinational CPU/host grant selector
module arb_prio_sel
  import mcu_pkg::*;
(
  input  logic       c_req,
  input  logic       h_req,
  input  arb_state_t state,
  input  logic       wait_max,
  output logic       c_gnt,
  output logic       h_gnt
);

  always_comb begin
    h_gnt = h_req && ((state == ARB_HOST_LOCK) || wait_max || !c_req);
    // After a maximal burst the CPU gets one guaranteed slot.
    if ((state == ARB_FORCE_REL) && c_req) begin
      h_gnt = 1'b0;
    end
    c_gnt = c_req && !h_gnt;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between CPU and host
module dmem_arbiter
  import mcu_pkg::*;
#(
  parameter int ADDR_W    = MCU_ADDR_W,
  parameter int DATA_W    = MCU_DATA_W,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_e,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do
);

  localparam logic [3:0] WAIT_MAX   = 4'(MAX_WAIT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_t        state, state_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic [7:0]        burst_cnt, burst_nxt;
  logic              sel_c, sel_h;
  logic              c_pend, h_pend;
  logic [DATA_W-1:0] c_rdata_q, h_rdata_q;

  arb_prio_sel u_sel (
    .c_req    (c_req),
    .h_req    (h_req),
    .state    (state),
    .wait_max (wait_cnt == WAIT_MAX),
    .c_gnt    (sel_c),
    .h_gnt    (sel_h)
  );

  // Grants are held off combinationally while reset is asserted.
  assign c_gnt    = rst && sel_c;
  assign h_gnt    = rst && sel_h;
  assign mem_e    = c_gnt || h_gnt;
  assign mem_we   = h_gnt ? h_we : (c_gnt && c_we);
  assign mem_addr = h_gnt ? h_addr  : (c_gnt ? c_addr  : '0);
  assign mem_di   = h_gnt ? h_wdata : (c_gnt ? c_wdata : '0);

  always_comb begin
    state_nxt = ARB_IDLE;
    burst_nxt = '0;
    wait_nxt  = '0;
    if (h_req && !h_gnt) begin
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 4'd1;
    end
    if (h_gnt) begin
      if (!h_lock) begin
        state_nxt = ARB_HOST_OWN;
      end else if (burst_cnt == BURST_LAST) begin
        state_nxt = ARB_FORCE_REL;
      end else begin
        state_nxt = ARB_HOST_LOCK;
        burst_nxt = burst_cnt + 8'd1;
      end
    end else if (c_gnt) begin
      state_nxt = ARB_CPU_OWN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // mem_do arrives one cycle after the read; pend marks whose read it is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_pend    <= 1'b0;
      h_pend    <= 1'b0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      c_pend <= c_gnt && !c_we;
      h_pend <= h_gnt && !h_we;
      if (c_pend) c_rdata_q <= mem_do;
      if (h_pend) h_rdata_q <= mem_do;
    end
  end

  assign c_rvalid = c_pend;
  assign h_rvalid = h_pend;
  assign c_rdata  = c_pend ? mem_do : c_rdata_q;
  assign h_rdata  = h_pend ? mem_do : h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       c_req, c_we, c_gnt, c_rvalid;
  logic [3:0] c_addr;
  logic [7:0] c_wdata, c_rdata;
  logic       h_req, h_we, h_lock, h_gnt, h_rvalid;
  logic [3:0] h_addr;
  logic [7:0] h_wdata, h_rdata;
  logic       mem_e, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_di;
  logic [7:0] mem_do = 8'h00;
  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  // Synchronous 16x8 memory; address 3 is preloaded while reset is low.
  always @(posedge clk) begin
    if (!rst) begin
      mem[3] <= 8'h5A;
    end else if (mem_e) begin
      if (mem_we) mem[mem_addr] <= mem_di;
      else        mem_do <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0; h_lock = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    drop_all();
    rst = 1'b0;
    c_req = 1; h_req = 1;
    repeat (2) @(negedge clk);
    check("rst_gnt", {c_gnt, h_gnt, mem_e, mem_we}, 4'b0000);
    check("rst_rv", {c_rvalid, h_rvalid}, 2'b00);
    check("rst_rdata", {c_rdata, h_rdata}, 16'h0000);
    check("rst_state", dut.state, ARB_IDLE);
    check("rst_wait", dut.wait_cnt, 0);
    drop_all();
    rst = 1'b1;
    tick();

    // CPU read alone
    c_req = 1; c_we = 0; c_addr = 4'd3;
    @(negedge clk);
    check("rd_gnt", {c_gnt, h_gnt, mem_e, mem_we}, 4'b1010);
    check("rd_addr", mem_addr, 4'd3);
    tick();
    c_req = 0;
    @(negedge clk);
    check("rd_rvalid", {c_rvalid, h_rvalid}, 2'b10);
    check("rd_rdata", c_rdata, 8'h5A);
    tick();
    @(negedge clk);
    check("rd_pulse", {c_rvalid, c_rdata}, {1'b0, 8'h5A});
    tick();

    // Contention: host forced in after MAX_WAIT denials
    c_req = 1; c_addr = 4'd1; h_req = 1; h_addr = 4'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("cont_%0d", i), {c_gnt, h_gnt},
            (i == 4 || i == 9) ? 2'b01 : 2'b10);
      if (i == 4) check("cont_wait_max", dut.wait_cnt, 4);
      tick();
    end
    drop_all();
    tick(); tick();

    // Host burst with lock, forced release, then wait rules again
    c_req = 1; c_addr = 4'd1; h_req = 1; h_lock = 1; h_addr = 4'd2;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("burst_%0d", i), {c_gnt, h_gnt},
            ((i >= 4 && i <= 11) || i >= 16) ? 2'b01 : 2'b10);
      if (i == 12) check("burst_force_rel", dut.state, ARB_FORCE_REL);
      tick();
    end
    h_req = 0;
    @(negedge clk);
    check("lock_drop", {c_gnt, h_gnt}, 2'b10);
    tick();
    drop_all();
    tick();

    // Host write then CPU read of the same address
    h_req = 1; h_we = 1; h_addr = 4'd7; h_wdata = 8'hC3;
    @(negedge clk);
    check("hw_gnt", {h_gnt, mem_we, mem_addr, mem_di}, {1'b1, 1'b1, 4'd7, 8'hC3});
    tick();
    drop_all();
    c_req = 1; c_addr = 4'd7;
    @(negedge clk);
    check("cr_gnt", {c_gnt, mem_we, c_rvalid, h_rvalid}, 4'b1000);
    tick();
    c_req = 0;
    @(negedge clk);
    check("cr_data", {c_rvalid, h_rvalid, c_rdata}, {2'b10, 8'hC3});
    tick();

    // Async reset between a host read grant and its return
    h_req = 1; h_we = 0; h_addr = 4'd7;
    @(negedge clk);
    check("hr_gnt", {h_gnt, mem_e, mem_we}, 3'b110);
    #2 rst = 1'b0;
    #1 check("hr_rst_gnt", {h_gnt, mem_e}, 2'b00);
    @(negedge clk);
    check("hr_rst_rv", {h_rvalid, h_rdata}, {1'b0, 8'h00});
    check("hr_rst_state", {dut.state, dut.wait_cnt}, {ARB_IDLE, 4'd0});
    h_req = 0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("hr_after", {mem_e, h_rvalid, c_rvalid}, 3'b000);
    tick();

    // Idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i),
            {mem_e, c_gnt, h_gnt, c_rvalid, h_rvalid, dut.wait_cnt}, 9'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
